// File: rtl/ps2_scan_controller.sv
// PS/2 keyboard receive controller: synchronises the pins, captures 11-bit frames
// and decodes scancode-set-2 E0/F0 prefixes. Optional macro: PS2_PARITY_CHECK_EN.
module ps2_scan_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       clear,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       extended,
  output logic       released,
  output logic       code_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned FRAME_W = 11;
  localparam int unsigned BITCNT_W = 4;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LAST_BIT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    CHECK  = 2'd2,
    DECODE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 clk_s1_q, clk_s1_d;
  logic                 clk_s2_q, clk_s2_d;
  logic                 clk_prev_q, clk_prev_d;
  logic                 data_s1_q, data_s1_d;
  logic                 data_s2_q, data_s2_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic                 ext_flag_q, ext_flag_d;
  logic                 brk_flag_q, brk_flag_d;
  logic [7:0]           code_q, code_d;
  logic                 extended_q, extended_d;
  logic                 released_q, released_d;
  logic                 code_valid_q, code_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;

  logic                 fe;
  logic                 bit_in;
  logic                 parity_ok;
  logic                 frame_ok;
  logic [7:0]           rx_byte;

  assign fe      = clk_prev_q & ~clk_s2_q;
  assign bit_in  = data_s2_q;
  assign rx_byte = frame_q[8:1];

  // Odd parity across data + parity bit; ignored when the check is compiled out.
`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^frame_q[9:1];
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_ok = frame_q[10] & ~frame_q[0] & parity_ok;

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    bitcnt_d     = bitcnt_q;
    idle_cnt_d   = idle_cnt_q;
    ext_flag_d   = ext_flag_q;
    brk_flag_d   = brk_flag_q;
    code_d       = code_q;
    extended_d   = extended_q;
    released_d   = released_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    data_s1_d  = ps2_data;
    data_s2_d  = data_s1_q;

    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (fe && !bit_in) begin
          state_d  = RECV;
          bitcnt_d = BITCNT_W'(1);
          frame_d  = {bit_in, frame_q[FRAME_W-1:1]};
        end
      end

      RECV: begin
        if (fe) begin
          frame_d    = {bit_in, frame_q[FRAME_W-1:1]};
          idle_cnt_d = '0;
          if (bitcnt_q == BITCNT_W'(LAST_BIT)) begin
            state_d  = CHECK;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + BITCNT_W'(1);
          end
        end else if (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = IDLE;
          bitcnt_d    = '0;
          idle_cnt_d  = '0;
          frame_err_d = 1'b1;
          ext_flag_d  = 1'b0;
          brk_flag_d  = 1'b0;
        end else begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end

      // Decode results are registered here so they are visible during DECODE,
      // two cycles after the stop-bit edge.
      CHECK: begin
        if (!frame_ok) begin
          state_d     = IDLE;
          frame_err_d = 1'b1;
          ext_flag_d  = 1'b0;
          brk_flag_d  = 1'b0;
        end else begin
          state_d = DECODE;
          if (rx_byte == 8'hE0) begin
            ext_flag_d = 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk_flag_d = 1'b1;
          end else begin
            code_d       = rx_byte;
            extended_d   = ext_flag_q;
            released_d   = brk_flag_q;
            code_valid_d = 1'b1;
            ext_flag_d   = 1'b0;
            brk_flag_d   = 1'b0;
          end
        end
      end

      DECODE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RECV);
  end

  always_ff @(posedge CLOCK_50) begin
    if (clear) begin
      state_q      <= IDLE;
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      clk_prev_q   <= 1'b1;
      data_s1_q    <= 1'b1;
      data_s2_q    <= 1'b1;
      frame_q      <= '0;
      bitcnt_q     <= '0;
      idle_cnt_q   <= '0;
      ext_flag_q   <= 1'b0;
      brk_flag_q   <= 1'b0;
      code_q       <= 8'h00;
      extended_q   <= 1'b0;
      released_q   <= 1'b0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      clk_prev_q   <= clk_prev_d;
      data_s1_q    <= data_s1_d;
      data_s2_q    <= data_s2_d;
      frame_q      <= frame_d;
      bitcnt_q     <= bitcnt_d;
      idle_cnt_q   <= idle_cnt_d;
      ext_flag_q   <= ext_flag_d;
      brk_flag_q   <= brk_flag_d;
      code_q       <= code_d;
      extended_q   <= extended_d;
      released_q   <= released_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign code       = code_q;
  assign extended   = extended_q;
  assign released   = released_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: doc/ps2_scan_controller.md
Name: ps2_scan_controller

Overview:
Receive-side controller for the PS/2 keyboard port.
- Synchronises the raw ps2_clk/ps2_data pins and sequences the 11-bit frame capture on ps2_clk falling edges.
- Validates each frame and runs the scancode-set-2 prefix state (E0 extended, F0 break).
- Emits one decoded key event per complete make or break sequence to the HEX display / game logic.

Parameters:
TIMEOUT_CYCLES, 50000, CLOCK_50 cycles without a ps2_clk falling edge mid-frame before the frame is aborted (1 ms at 50 MHz).

Ports:
CLOCK_50  in  1  system clock, 50 MHz
clear  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock pin, asynchronous
ps2_data  in  1  raw PS/2 data pin, asynchronous
code  out  8  final scancode byte of the last event
extended  out  1  last event was E0-prefixed
released  out  1  last event was a break (F0-prefixed)
code_valid  out  1  one-cycle pulse; code/extended/released updated in the same cycle
frame_err  out  1  one-cycle pulse on any rejected frame
busy  out  1  high while a frame is being received (state RECV)

Behaviour:
- One clock, CLOCK_50. clear is synchronous and active-high. All state updates on posedge CLOCK_50.
- Reset values: code=0x00, extended=0, released=0, code_valid=0, frame_err=0, busy=0, FSM=IDLE, bit counter=0, prefix flags=0, synchroniser flops=1.
- Input path: 2-flop synchroniser on each pin plus a previous-value register on synced clk.
- Falling edge (fe) = prev 1 and current 0. Data is sampled from synced ps2_data in the fe cycle.
- Frame format: start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1.
- FSM states:
  - IDLE: on fe with data=0, go to RECV with bitcnt=1. On fe with data=1 (bad start), stay in IDLE; no error is raised.
  - RECV: each fe shifts data into an 11-bit frame register and increments bitcnt. When the fe for bitcnt=10 (stop bit) arrives, go to CHECK. An idle counter resets on every fe; when it reaches TIMEOUT_CYCLES, pulse frame_err, clear the prefix flags and go to IDLE.
  - CHECK (1 cycle): the frame is bad if stop=0, or if parity fails (see Optional Feature). A bad frame pulses frame_err, clears the prefix flags and goes to IDLE. A good frame goes to DECODE.
  - DECODE (1 cycle):
    - byte 0xE0: set ext_flag.
    - byte 0xF0: set brk_flag.
    - any other byte: drive code=byte, extended=ext_flag, released=brk_flag, pulse code_valid, clear both flags.
    - Then go to IDLE.
- Latency: code_valid asserts exactly 2 cycles after the cycle in which the stop-bit fe is detected.
- busy=1 only in RECV.
- Prefix flags persist across frames until consumed, until an error, or until clear.
- Repeated prefixes (E0 E0 or F0 F0) are idempotent.
- clear mid-frame aborts immediately. No code_valid or frame_err is produced for the partial frame.
- code/extended/released hold their value between events.
- code_valid and frame_err never assert in the same cycle.
- fe edges arriving during CHECK/DECODE are ignored. The PS/2 bit period (≥60 µs) makes this unreachable in normal operation.

Optional Feature:
PS2_PARITY_CHECK_EN
- Defined: CHECK rejects a frame whose 8 data bits plus parity bit contain an even number of ones. The frame raises frame_err, produces no event and clears the prefix flags.
- Undefined: the parity bit is captured but ignored; only the stop bit is checked.

Test Plan:
- Make 'A': frame 0,[0x1C LSB first],parity 0,stop 1 -> one code_valid, code=0x1C, extended=0, released=0.
- Break 'A': frames F0 then 1C -> exactly one code_valid (after the 1C frame), code=0x1C, released=1, extended=0; no pulse after F0.
- Extended break up-arrow: frames E0, F0, 75 (parity 0) -> one code_valid, code=0x75, extended=1, released=1; next frame 1C reports extended=0, released=0.
- Parity error with macro defined: 0x1C sent with parity 1 -> frame_err pulse, no code_valid; without macro -> code_valid, code=0x1C.
- Timeout: 5 bits then clock stalled TIMEOUT_CYCLES -> frame_err one pulse, busy drops; subsequent good 0x1C frame decodes correctly.
- Reset mid-sequence: E0 frame, then clear pulsed for 1 cycle during the next frame's bit 4 -> all outputs at reset values; following 0x1C frame reports extended=0.
